// File: rtl/mips16_regfile_pkg.sv
// -----------------------------------------------------------------------------
// mips16_regfile_pkg
// Shared constants and helpers for the 16-bit MIPS register file.
//   REG_COUNT   : number of architectural registers
//   REG_ADDR_W  : width of a binary register address
//   DATA_W      : default register data width
//   R0_IDX      : index of the hardwired-zero register
//   onehot_to_index() : one-hot select -> binary index. It is also used by the
//                       hazard unit, so it lives here rather than in a module.
// -----------------------------------------------------------------------------
package mips16_regfile_pkg;

    localparam int REG_COUNT  = 16;
    localparam int REG_ADDR_W = 4;
    localparam int DATA_W     = 16;

    localparam logic [REG_ADDR_W-1:0] R0_IDX = '0;

    // OR-reduction of the indices of all set bits. For a one-hot input this is
    // exactly the set-bit index; for malformed inputs the result is meaningless
    // and callers must qualify it with a one-hot check.
    function automatic logic [REG_ADDR_W-1:0] onehot_to_index(
        input logic [REG_COUNT-1:0] oh
    );
        logic [REG_ADDR_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < REG_COUNT; i++) begin
            if (oh[i]) begin
                idx = idx | REG_ADDR_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/mips16_regfile_onehot_check.sv
// -----------------------------------------------------------------------------
// mips16_regfile_onehot_check
// Purely combinational qualifier for the write-select word coming from the
// 4-to-16 write-address decoder.
//   wsel      in  [REG_COUNT-1:0] one-hot write select
//   is_onehot out 1               exactly one bit of wsel is set
//   index     out [REG_ADDR_W-1:0] binary index of the set bit (valid only
//                                  when is_onehot=1)
// -----------------------------------------------------------------------------
module mips16_regfile_onehot_check
    import mips16_regfile_pkg::*;
(
    input  logic [REG_COUNT-1:0]  wsel,
    output logic                  is_onehot,
    output logic [REG_ADDR_W-1:0] index
);

    // Non-zero and clearing the lowest set bit leaves nothing: exactly one bit.
    assign is_onehot = (wsel != '0) && ((wsel & (wsel - REG_COUNT'(1))) == '0);
    assign index     = onehot_to_index(wsel);

endmodule

// File: rtl/mips16_regfile.sv
// -----------------------------------------------------------------------------
// mips16_regfile
// 16 x WIDTH general-purpose register file for the 16-bit MIPS datapath.
// Two combinational read ports (ID stage), one write port (WB stage) addressed
// by a one-hot select, R0 hardwired to zero, optional same-cycle write-to-read
// bypass and a sticky error flag for malformed write selects.
//   clk       in  clock, all state updates on the rising edge
//   rst       in  synchronous active-high reset (priority over everything)
//   we        in  write enable
//   wsel      in  [15:0] one-hot write select
//   wdata     in  [WIDTH-1:0] write data
//   raddr_a   in  [3:0] read address port A (rs)
//   raddr_b   in  [3:0] read address port B (rt)
//   rdata_a   out [WIDTH-1:0] read data port A
//   rdata_b   out [WIDTH-1:0] read data port B
//   clear_err in  clears sel_err (a simultaneous new error wins)
//   sel_err   out sticky: a write was attempted with a non-one-hot wsel
// -----------------------------------------------------------------------------
module mips16_regfile
    import mips16_regfile_pkg::*;
#(
    parameter int WIDTH  = DATA_W,
    parameter int BYPASS = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [REG_COUNT-1:0]  wsel,
    input  logic [WIDTH-1:0]      wdata,
    input  logic [REG_ADDR_W-1:0] raddr_a,
    input  logic [REG_ADDR_W-1:0] raddr_b,
    output logic [WIDTH-1:0]      rdata_a,
    output logic [WIDTH-1:0]      rdata_b,
    input  logic                  clear_err,
    output logic                  sel_err
);

    localparam bit BYP_EN = (BYPASS != 0);

    logic [WIDTH-1:0]      regs_q [REG_COUNT];
    logic                  sel_err_q;
    logic                  sel_err_d;
    logic                  is_onehot;
    logic [REG_ADDR_W-1:0] widx;
    logic                  wvalid;
    logic                  byp_a;
    logic                  byp_b;

    mips16_regfile_onehot_check u_onehot_check (
        .wsel      (wsel),
        .is_onehot (is_onehot),
        .index     (widx)
    );

    assign wvalid = we && is_onehot;

    // A malformed select only counts when a write is actually requested.
    always_comb begin
        sel_err_d = sel_err_q;
        if (we && !is_onehot) begin
            sel_err_d = 1'b1;
        end else if (clear_err) begin
            sel_err_d = 1'b0;
        end
    end

    // R0 is never written, so its storage stays at its reset value; the read
    // path forces zero anyway so R0 reads are independent of storage.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs_q[i] <= '0;
            end
            sel_err_q <= 1'b0;
        end else begin
            if (wvalid && (widx != R0_IDX)) begin
                regs_q[widx] <= wdata;
            end
            sel_err_q <= sel_err_d;
        end
    end

    // Bypass never applies to R0 so the hardwired zero holds during writes.
    assign byp_a = BYP_EN && wvalid && (raddr_a == widx) && (raddr_a != R0_IDX);
    assign byp_b = BYP_EN && wvalid && (raddr_b == widx) && (raddr_b != R0_IDX);

    always_comb begin
        rdata_a = '0;
        rdata_b = '0;
        if (raddr_a != R0_IDX) begin
            rdata_a = byp_a ? wdata : regs_q[raddr_a];
        end
        if (raddr_b != R0_IDX) begin
            rdata_b = byp_b ? wdata : regs_q[raddr_b];
        end
    end

    assign sel_err = sel_err_q;

endmodule

// File: tb/tb_mips16_regfile.sv
// -----------------------------------------------------------------------------
// tb_mips16_regfile
// Bench for mips16_regfile (WIDTH=16, BYPASS=1): directed vector table with
// hand-derived expectations, then randomized traffic checked against a
// behavioural register-file model.
// -----------------------------------------------------------------------------
module tb_mips16_regfile;

    typedef struct {
        logic        rst;
        logic        we;
        logic [15:0] wsel;
        logic [15:0] wdata;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic        clr;
        logic [15:0] exp_a;    // same-cycle read, port A
        logic [15:0] exp_b;    // same-cycle read, port B
        logic        exp_err;  // sel_err after the rising edge
    } vec_t;

    logic        clk = 1'b0;
    logic        rst, we, clear_err, sel_err;
    logic [15:0] wsel, wdata, rdata_a, rdata_b;
    logic [3:0]  raddr_a, raddr_b;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state
    logic [15:0] m_regs [16];
    logic        m_err;

    vec_t tbl [$];

    mips16_regfile #(.WIDTH(16), .BYPASS(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .we        (we),
        .wsel      (wsel),
        .wdata     (wdata),
        .raddr_a   (raddr_a),
        .raddr_b   (raddr_b),
        .rdata_a   (rdata_a),
        .rdata_b   (rdata_b),
        .clear_err (clear_err),
        .sel_err   (sel_err)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [15:0] model_read(input logic [3:0] a, input logic w_en,
                                               input logic [15:0] sel, input logic [15:0] d);
        if (a == 4'd0) return 16'h0000;
        if (w_en && $countones(sel) == 1 && sel[a]) return d;
        return m_regs[a];
    endfunction

    task automatic model_clock(input vec_t v);
        if (v.rst) begin
            for (int i = 0; i < 16; i++) m_regs[i] = 16'h0000;
            m_err = 1'b0;
        end else begin
            if (v.we && $countones(v.wsel) == 1) begin
                for (int i = 1; i < 16; i++) if (v.wsel[i]) m_regs[i] = v.wdata;
            end
            if (v.we && $countones(v.wsel) != 1) m_err = 1'b1;
            else if (v.clr) m_err = 1'b0;
        end
    endtask

    // ---------------- driver ----------------
    // Drives one cycle; table rows use their own expectations, random rows
    // use the model.
    task automatic run_vec(input vec_t v, input string tag, input bit from_table);
        logic [15:0] ea, eb;
        logic        ee;
        @(negedge clk);
        rst = v.rst; we = v.we; wsel = v.wsel; wdata = v.wdata;
        raddr_a = v.ra; raddr_b = v.rb; clear_err = v.clr;
        #1;
        ea = from_table ? v.exp_a : model_read(v.ra, v.we, v.wsel, v.wdata);
        eb = from_table ? v.exp_b : model_read(v.rb, v.we, v.wsel, v.wdata);
        check({tag, "_rdata_a"}, rdata_a, ea);
        check({tag, "_rdata_b"}, rdata_b, eb);
        @(posedge clk);
        model_clock(v);
        #1;
        ee = from_table ? v.exp_err : m_err;
        check({tag, "_sel_err"}, {15'd0, sel_err}, {15'd0, ee});
    endtask

    function automatic vec_t mk(input logic r, input logic w, input logic [15:0] s,
                                input logic [15:0] d, input logic [3:0] a, input logic [3:0] b,
                                input logic c, input logic [15:0] xa, input logic [15:0] xb,
                                input logic xe);
        vec_t v;
        v.rst = r; v.we = w; v.wsel = s; v.wdata = d; v.ra = a; v.rb = b;
        v.clr = c; v.exp_a = xa; v.exp_b = xb; v.exp_err = xe;
        return v;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        vec_t v;
        rst = 1'b1; we = 1'b0; wsel = '0; wdata = '0;
        raddr_a = '0; raddr_b = '0; clear_err = 1'b0;
        for (int i = 0; i < 16; i++) m_regs[i] = 16'hxxxx;
        m_err = 1'bx;
        repeat (2) @(posedge clk);
        v = mk(1, 0, 16'h0, 16'h0, 0, 0, 0, 16'h0, 16'h0, 0);
        model_clock(v);
        #1;
        rst = 1'b0;
        check("reset_sel_err", {15'd0, sel_err}, 16'd0);

        // Post-reset read of every address on both ports
        for (int i = 0; i < 16; i++) begin
            run_vec(mk(0, 0, 16'h0, 16'h0, 4'(i), 4'(15 - i), 0, 16'h0, 16'h0, 0),
                    $sformatf("rst_read%0d", i), 1'b1);
        end

        //          rst we wsel      wdata     ra rb clr exp_a     exp_b     err
        tbl.push_back(mk(0, 1, 16'h0020, 16'hBEEF, 5, 5, 0, 16'hBEEF, 16'hBEEF, 0)); // bypass both ports
        tbl.push_back(mk(0, 0, 16'h0020, 16'h0000, 5, 5, 0, 16'hBEEF, 16'hBEEF, 0)); // stored value
        tbl.push_back(mk(0, 1, 16'h0001, 16'h1234, 0, 0, 0, 16'h0000, 16'h0000, 0)); // R0 write ignored
        tbl.push_back(mk(0, 0, 16'h0000, 16'h0000, 0, 5, 0, 16'h0000, 16'hBEEF, 0)); // R0 still zero
        tbl.push_back(mk(0, 1, 16'h0008, 16'h00AA, 3, 4, 0, 16'h00AA, 16'h0000, 0)); // R3 = AA
        tbl.push_back(mk(0, 1, 16'h0018, 16'hFFFF, 3, 4, 0, 16'h00AA, 16'h0000, 1)); // two bits: no bypass, error
        tbl.push_back(mk(0, 0, 16'h0000, 16'h0000, 3, 4, 0, 16'h00AA, 16'h0000, 1)); // sticky, nothing written
        tbl.push_back(mk(0, 0, 16'h0000, 16'h0000, 3, 3, 1, 16'h00AA, 16'h00AA, 0)); // clear alone
        tbl.push_back(mk(0, 1, 16'h0000, 16'h1111, 0, 3, 0, 16'h0000, 16'h00AA, 1)); // zero select
        tbl.push_back(mk(0, 0, 16'hFFFF, 16'h2222, 4, 3, 1, 16'h0000, 16'h00AA, 0)); // we=0 ignores wsel
        tbl.push_back(mk(0, 0, 16'h0018, 16'h3333, 4, 3, 0, 16'h0000, 16'h00AA, 0)); // we=0 malformed: no error
        tbl.push_back(mk(0, 1, 16'h0018, 16'h3333, 4, 3, 0, 16'h0000, 16'h00AA, 1)); // error again
        tbl.push_back(mk(0, 1, 16'h0003, 16'h4444, 0, 1, 1, 16'h0000, 16'h0000, 1)); // set wins over clear
        tbl.push_back(mk(0, 0, 16'h0000, 16'h0000, 1, 1, 1, 16'h0000, 16'h0000, 0)); // clear
        tbl.push_back(mk(0, 1, 16'h0080, 16'h5555, 7, 7, 0, 16'h5555, 16'h5555, 0)); // R7 = 5555
        tbl.push_back(mk(0, 1, 16'h0000, 16'h0000, 7, 3, 0, 16'h5555, 16'h00AA, 1)); // arm error before reset
        tbl.push_back(mk(1, 1, 16'h0080, 16'h9999, 7, 6, 1, 16'h9999, 16'h0000, 0)); // reset beats write
        tbl.push_back(mk(0, 0, 16'h0000, 16'h0000, 7, 3, 0, 16'h0000, 16'h0000, 0)); // all cleared
        tbl.push_back(mk(0, 1, 16'h8000, 16'hA5A5, 15, 14, 0, 16'hA5A5, 16'h0000, 0)); // top register
        tbl.push_back(mk(0, 0, 16'h0000, 16'h0000, 15, 15, 0, 16'hA5A5, 16'hA5A5, 0));

        foreach (tbl[i]) begin
            run_vec(tbl[i], $sformatf("vec%0d", i), 1'b1);
        end

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            v.rst  = ($urandom_range(0, 49) == 0);
            v.we   = ($urandom_range(0, 3) != 0);
            v.wsel = ($urandom_range(0, 9) < 7) ? (16'h1 << $urandom_range(0, 15))
                                                : 16'($urandom_range(0, 65535));
            if ($urandom_range(0, 19) == 0) v.wsel = 16'h0000;
            v.wdata = 16'($urandom_range(0, 65535));
            v.ra  = 4'($urandom_range(0, 15));
            v.rb  = ($urandom_range(0, 3) == 0) ? v.ra : 4'($urandom_range(0, 15));
            v.clr = ($urandom_range(0, 7) == 0);
            v.exp_a = '0; v.exp_b = '0; v.exp_err = 1'b0;
            run_vec(v, $sformatf("rand%0d", n), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mips16_regfile.md
Name: mips16_regfile

Overview:
- 16-entry x 16-bit general-purpose register file for the 16-bit MIPS datapath.
- Sits directly downstream of the 4-to-16 write-address decoder. It takes that decoder's one-hot 16-bit write-select word, not a binary write address.
- Provides two read ports for the ID stage and one write port driven from WB.
- Adds same-cycle write-to-read bypass, hardwired-zero R0, and a sticky error flag for malformed (non-one-hot) write selects.

Parameters:
- WIDTH, 16, data width of each register.
- BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = reads return stored value only.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- we  input  1  write enable from WB stage.
- wsel  input  16  one-hot write select from the write-address decoder; bit i selects register i.
- wdata  input  WIDTH  write data.
- raddr_a  input  4  read address, port A (rs).
- raddr_b  input  4  read address, port B (rt).
- rdata_a  output  WIDTH  read data, port A.
- rdata_b  output  WIDTH  read data, port B.
- clear_err  input  1  clears sel_err.
- sel_err  output  1  sticky flag: a write was attempted with a non-one-hot wsel.

Behaviour:
- Reset:
  - At a rising clk with rst=1, registers R0..R15 = 0 and sel_err = 0.
  - rst has priority over we and clear_err.
  - Reset asserted mid-write discards the write.
- Write validity:
  - wvalid = we AND (popcount(wsel) == 1).
  - Computed combinationally from the current inputs.
- Write:
  - On a rising clk with rst=0 and wvalid=1, register i takes wdata, where i is the set bit of wsel.
  - Latency 1 cycle: the stored value is visible from the next cycle.
- R0:
  - Always reads 0.
  - A valid write with wsel = 16'h0001 is accepted silently: no storage change, no error.
- Malformed select:
  - Applies when we=1 and wsel is 16'h0000 or has two or more bits set.
  - No register changes, and sel_err <= 1 at the next rising edge.
- we=0: wsel is ignored entirely, including malformed values; no error.
- Error flag:
  - sel_err stays 1 until a rising edge with clear_err=1 and no new error.
  - A new error in the same cycle as clear_err=1 leaves sel_err at 1 (set wins).
- Reads:
  - Combinational, zero latency. rdata_x = reg[raddr_x], with R0 forced to 0.
- Bypass (BYPASS=1):
  - Applies when wvalid=1, raddr_x equals the set-bit index of wsel, and raddr_x != 0.
  - Then rdata_x = wdata in the same cycle.
  - Port A and port B are bypassed independently; both may bypass at once.
- BYPASS=0: reads show the pre-write value until the next cycle.
- Both read ports may address the same register simultaneously; both return the same value.
- No X propagation: all storage is defined after the first reset.

Decomposition:
- Shared package/header holds:
  - REG_COUNT = 16, REG_ADDR_W = 4, DATA_W = 16.
  - R0 index constant.
  - The one-hot-to-index function, reused by the bypass compare and later by the hazard unit.
- One natural sub-module: regfile_onehot_check.
  - Input: wsel (16 bits).
  - Outputs: is_onehot (1 bit) and index (4 bits).
  - Purely combinational.
  - Instantiated once; the index output feeds the bypass comparators.
- The storage array and read muxes live in the top module. No per-register sub-module is needed.

Test Plan:
- Reset, then read all 16 addresses on both ports -> every rdata = 16'h0000, sel_err = 0.
- we=1, wsel=16'h0020, wdata=16'hBEEF; the same cycle raddr_a=5 -> rdata_a = 16'hBEEF immediately (bypass). Next cycle with we=0, raddr_a=5 and raddr_b=5 -> both 16'hBEEF.
- we=1, wsel=16'h0001, wdata=16'h1234, raddr_a=0 -> rdata_a = 0 in the same cycle and the next; sel_err stays 0.
- Write R3=16'h00AA; then we=1, wsel=16'h0018, wdata=16'hFFFF -> R3 still 16'h00AA, R4 still 0, sel_err = 1 next cycle. Repeat with wsel=16'h0000 -> sel_err = 1.
- With sel_err=1: pulse clear_err alone -> sel_err = 0 next cycle. Drive clear_err=1 together with we=1, wsel=16'h0003 -> sel_err remains 1.
- Write R7=16'h5555, then assert rst in the same cycle as we=1, wsel=16'h0080, wdata=16'h9999 -> next cycle R7 = 0, sel_err = 0.
